// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues pipelined in-order fetches from a local PC,
// buffers returned instructions in a prefetch FIFO and hands them to decode.
module fetch_queue #(
  parameter int unsigned         ADDR_W          = 32,
  parameter int unsigned         INSTR_W         = 32,
  parameter int unsigned         DEPTH           = 4,
  parameter int unsigned         MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0]   INIT_ADDRESS    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDR_W-1:0]        imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [INSTR_W-1:0]       imem_resp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pc_plus_four,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned OS_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [OS_W-1:0]    outstanding, drop_cnt, live;
  logic [ADDR_W-1:0]  tag_mem   [MAX_OUTSTANDING];
  logic [TAG_W-1:0]   tag_rd, tag_wr;
  logic [SUM_W-1:0]   credit_used;

  logic req_fire, resp_live, pop, has_entry;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  // Credit counts only live requests, so every live response is guaranteed a slot.
  always_comb begin
    live           = outstanding - drop_cnt;
    credit_used    = SUM_W'(live) + SUM_W'(count_q);
    has_entry      = (count_q != '0);
    imem_req_valid = reset && !redirect
                     && (outstanding < OS_W'(MAX_OUTSTANDING))
                     && (credit_used < SUM_W'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_live      = imem_resp_valid && !redirect && (drop_cnt == '0);
    out_valid      = has_entry && !redirect;
    pop            = out_valid && out_ready;
    out_instr        = has_entry ? instr_mem[rd_ptr] : '0;
    out_pc           = has_entry ? pc_mem[rd_ptr] : '0;
    out_pc_plus_four = has_entry ? pc_mem[rd_ptr] + ADDR_W'(4) : '0;
    count            = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= INIT_ADDRESS;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      outstanding <= outstanding + OS_W'(req_fire) - OS_W'(imem_resp_valid);
      if (req_fire)        tag_wr <= tag_next(tag_wr);
      // Tags are consumed by every response, doomed or not, to stay aligned.
      if (imem_resp_valid) tag_rd <= tag_next(tag_rd);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count_q  <= '0;
        drop_cnt <= outstanding - OS_W'(imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OS_W'(1);
        if (resp_live) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
        count_q <= count_q + CNT_W'(resp_live) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp_live) begin
      instr_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
    end
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
  end

endmodule
